// File: rtl/cmip_mem_rd_arbiter.sv
// Round-robin arbiter sharing one read port of a 1R1W memory among NUM_REQ requesters.
// In-flight reads are tracked by a {valid,id} pipeline matched to READ_LATENCY.
module cmip_mem_rd_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DPTH         = 16384,
  parameter int DATA_WDTH    = 2048,
  parameter int ADDR_WDTH    = $clog2(DPTH),
  parameter int READ_LATENCY = 4,
  parameter int ID_WDTH      = $clog2(NUM_REQ)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic [NUM_REQ-1:0]           i_req_vld,
  input  logic [NUM_REQ*ADDR_WDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]           o_req_rdy,
  output logic                         o_mem_rd,
  output logic [ADDR_WDTH-1:0]         o_mem_raddr,
  input  logic [DATA_WDTH-1:0]         i_mem_rdata,
  output logic [NUM_REQ-1:0]           o_rvld,
  output logic [ID_WDTH-1:0]           o_rid,
  output logic [DATA_WDTH-1:0]         o_rdata,
  output logic                         o_busy
);

  localparam logic [ID_WDTH:0]   NUM_REQ_W = (ID_WDTH+1)'(NUM_REQ);
  localparam logic [ID_WDTH-1:0] LAST_ID   = ID_WDTH'(NUM_REQ - 1);
  localparam int                 LAST_STG  = READ_LATENCY - 1;

  logic [ID_WDTH-1:0]   ptr_r;
  logic [ID_WDTH-1:0]   ptr_nxt_s;
  logic [ID_WDTH:0]     idx_sum_s;
  logic [ID_WDTH-1:0]   idx_s;
  logic [NUM_REQ-1:0]   grant_s;
  logic [ID_WDTH-1:0]   grant_id_s;
  logic                 grant_vld_s;
  logic [ADDR_WDTH-1:0] grant_addr_s;
  logic [ADDR_WDTH-1:0] raddr_r;
  logic [READ_LATENCY-1:0] vld_pipe_r;
  logic [ID_WDTH-1:0]   id_pipe_r [READ_LATENCY];
  logic [NUM_REQ-1:0]   rvld_nxt_s;
  logic [NUM_REQ-1:0]   rvld_r;
  logic [ID_WDTH-1:0]   rid_r;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    grant_s     = '0;
    grant_id_s  = '0;
    grant_vld_s = 1'b0;
    idx_sum_s   = '0;
    idx_s       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_sum_s = {1'b0, ptr_r} + (ID_WDTH+1)'(i);
      if (idx_sum_s >= NUM_REQ_W) begin
        idx_sum_s = idx_sum_s - NUM_REQ_W;
      end else begin
        idx_sum_s = idx_sum_s;
      end
      idx_s = idx_sum_s[ID_WDTH-1:0];
      if (i_en && !grant_vld_s && i_req_vld[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        grant_id_s     = idx_s;
        grant_vld_s    = 1'b1;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Selects the granted requester's address and the pointer that follows it.
  always_comb begin
    grant_addr_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id_s == ID_WDTH'(k)) begin
        grant_addr_s = i_req_addr[k*ADDR_WDTH +: ADDR_WDTH];
      end else begin
        grant_addr_s = grant_addr_s;
      end
    end
    ptr_nxt_s = (grant_id_s == LAST_ID) ? '0 : grant_id_s + ID_WDTH'(1);
  end

  // Pointer and read address advance only on a completed handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_r   <= '0;
      raddr_r <= '0;
    end else if (grant_vld_s) begin
      ptr_r   <= ptr_nxt_s;
      raddr_r <= grant_addr_s;
    end
  end

  // Tag pipeline; stage 0 coincides with the memory read strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        id_pipe_r[i] <= '0;
      end
    end else begin
      vld_pipe_r[0] <= grant_vld_s;
      id_pipe_r[0]  <= grant_id_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_r[i] <= vld_pipe_r[i-1];
        id_pipe_r[i]  <= id_pipe_r[i-1];
      end
    end
  end

  // Decodes the last tag stage into a one-hot return valid.
  always_comb begin
    rvld_nxt_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rvld_nxt_s[k] = vld_pipe_r[LAST_STG] && (id_pipe_r[LAST_STG] == ID_WDTH'(k));
    end
  end

  // Return valid pulses for one cycle; the id keeps its last value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvld_r <= '0;
      rid_r  <= '0;
    end else begin
      rvld_r <= rvld_nxt_s;
      if (vld_pipe_r[LAST_STG]) begin
        rid_r <= id_pipe_r[LAST_STG];
      end
    end
  end

  assign o_req_rdy   = grant_s;
  assign o_mem_rd    = vld_pipe_r[0];
  assign o_mem_raddr = raddr_r;
  assign o_rvld      = rvld_r;
  assign o_rid       = rid_r;
  assign o_rdata     = i_mem_rdata;
  assign o_busy      = |vld_pipe_r;

endmodule

// File: tb/tb_cmip_mem_rd_arbiter.sv
// Directed bench for cmip_mem_rd_arbiter: default build plus a READ_LATENCY=1 build,
// each fed by a simple delayed-address memory model.
module tb_cmip_mem_rd_arbiter;

  localparam int NR = 4;
  localparam int AW = 14;
  localparam int DW = 2048;
  localparam int DW1 = 32;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [NR-1:0]   vld;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   rdy;
  logic            mem_rd;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   mem_rdata;
  logic [NR-1:0]   rvld;
  logic [1:0]      rid;
  logic [DW-1:0]   rdata;
  logic            busy;

  logic            en1;
  logic [NR-1:0]   vld1;
  logic [NR*AW-1:0] req_addr1;
  logic [NR-1:0]   rdy1;
  logic            mem_rd1;
  logic [AW-1:0]   raddr1;
  logic [DW1-1:0]  mem_rdata1;
  logic [NR-1:0]   rvld1;
  logic [1:0]      rid1;
  logic [DW1-1:0]  rdata1;
  logic            busy1;

  logic [AW-1:0]   mpipe [4];
  logic [AW-1:0]   m1_r;
  logic [DW-1:0]   exp_data;
  logic [DW1-1:0]  exp_data1;
  logic            seen_rvld;

  int n_checks = 0;
  int n_errors = 0;

  cmip_mem_rd_arbiter u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_req_vld(vld), .i_req_addr(req_addr),
    .o_req_rdy(rdy), .o_mem_rd(mem_rd), .o_mem_raddr(raddr), .i_mem_rdata(mem_rdata),
    .o_rvld(rvld), .o_rid(rid), .o_rdata(rdata), .o_busy(busy)
  );

  cmip_mem_rd_arbiter #(.DATA_WDTH(DW1), .READ_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_req_vld(vld1), .i_req_addr(req_addr1),
    .o_req_rdy(rdy1), .o_mem_rd(mem_rd1), .o_mem_raddr(raddr1), .i_mem_rdata(mem_rdata1),
    .o_rvld(rvld1), .o_rid(rid1), .o_rdata(rdata1), .o_busy(busy1)
  );

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {128{2'b10, a}};
  endfunction

  function automatic logic [DW1-1:0] data1_of(input logic [AW-1:0] a);
    return {2{2'b01, a}};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: data appears READ_LATENCY cycles after the address is sampled.
  always @(posedge clk) begin
    mpipe[0] <= raddr;
    mpipe[1] <= mpipe[0];
    mpipe[2] <= mpipe[1];
    mpipe[3] <= mpipe[2];
    m1_r     <= raddr1;
  end
  assign mem_rdata  = data_of(mpipe[3]);
  assign mem_rdata1 = data1_of(m1_r);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    vld   = '0;
    vld1  = '0;
    en    = 1'b1;
    en1   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; vld = '0; req_addr = '0;
    en1 = 1'b1; vld1 = '0; req_addr1 = '0;
    #12;
    check("rst_mem_rd", 64'(mem_rd), 64'(0));
    check("rst_raddr", 64'(raddr), 64'(0));
    check("rst_rvld", 64'(rvld), 64'(0));
    check("rst_rid", 64'(rid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Single request from requester 1
    reset_dut();
    tick(); vld = 4'b0010; req_addr[1*AW +: AW] = 14'h123; #1;
    check("sr_rdy_c0", 64'(rdy), 64'(4'b0010));
    tick(); vld = 4'b0000; #1;
    check("sr_mem_rd_c1", 64'(mem_rd), 64'(1));
    check("sr_raddr_c1", 64'(raddr), 64'(14'h123));
    check("sr_busy_c1", 64'(busy), 64'(1));
    check("sr_rvld_c1", 64'(rvld), 64'(0));
    for (int c = 2; c <= 4; c++) begin
      tick(); #1;
      check($sformatf("sr_busy_c%0d", c), 64'(busy), 64'(1));
      check($sformatf("sr_mem_rd_c%0d", c), 64'(mem_rd), 64'(0));
      check($sformatf("sr_rvld_c%0d", c), 64'(rvld), 64'(0));
    end
    tick(); #1;
    exp_data = data_of(14'h123);
    check("sr_rvld_c5", 64'(rvld), 64'(4'b0010));
    check("sr_rid_c5", 64'(rid), 64'(1));
    check("sr_rdata_lo_c5", rdata[63:0], exp_data[63:0]);
    check("sr_rdata_hi_c5", rdata[DW-1:DW-64], exp_data[DW-1:DW-64]);
    check("sr_busy_c5", 64'(busy), 64'(0));
    tick(); #1;
    check("sr_rvld_c6", 64'(rvld), 64'(0));
    check("sr_rid_hold_c6", 64'(rid), 64'(1));

    // Round robin with all four requesters valid for 8 cycles
    reset_dut();
    for (int k = 0; k < NR; k++) req_addr[k*AW +: AW] = AW'(14'h100 + k);
    for (int c = 0; c <= 12; c++) begin
      tick();
      vld = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) check($sformatf("rr_rdy_c%0d", c), 64'(rdy), 64'(1 << (c % 4)));
      if (c >= 1 && c <= 8) begin
        check($sformatf("rr_mem_rd_c%0d", c), 64'(mem_rd), 64'(1));
        check($sformatf("rr_raddr_c%0d", c), 64'(raddr), 64'(14'h100 + (c - 1) % 4));
      end
      if (c >= 5) begin
        exp_data = data_of(AW'(14'h100 + (c - 5) % 4));
        check($sformatf("rr_rvld_c%0d", c), 64'(rvld), 64'(1 << ((c - 5) % 4)));
        check($sformatf("rr_rid_c%0d", c), 64'(rid), 64'((c - 5) % 4));
        check($sformatf("rr_rdata_c%0d", c), rdata[63:0], exp_data[63:0]);
      end
    end
    tick(); #1;
    check("rr_rvld_end", 64'(rvld), 64'(0));
    check("rr_busy_end", 64'(busy), 64'(0));

    // Fairness after skip: pointer moved to 2, only requesters 0 and 3 valid
    reset_dut();
    tick(); vld = 4'b0010; #1;
    check("fs_rdy_setup", 64'(rdy), 64'(4'b0010));
    tick(); vld = 4'b1001; #1;
    check("fs_rdy_0", 64'(rdy), 64'(4'b1000));
    tick(); #1;
    check("fs_rdy_1", 64'(rdy), 64'(4'b0001));
    tick(); #1;
    check("fs_rdy_2", 64'(rdy), 64'(4'b1000));
    tick(); vld = 4'b0000;
    repeat (6) tick();
    check("fs_busy_drain", 64'(busy), 64'(0));

    // Enable low with two reads in flight
    reset_dut();
    tick(); vld = 4'b0011; #1;
    check("en_rdy_c0", 64'(rdy), 64'(4'b0001));
    tick(); #1;
    check("en_rdy_c1", 64'(rdy), 64'(4'b0010));
    tick(); en = 1'b0; vld = 4'b0101; #1;
    check("en_rdy_c2", 64'(rdy), 64'(0));
    check("en_mem_rd_c2", 64'(mem_rd), 64'(1));
    tick(); #1;
    check("en_rdy_c3", 64'(rdy), 64'(0));
    check("en_mem_rd_c3", 64'(mem_rd), 64'(0));
    check("en_busy_c3", 64'(busy), 64'(1));
    tick();
    tick(); #1;
    check("en_rvld_c5", 64'(rvld), 64'(4'b0001));
    tick(); #1;
    check("en_rvld_c6", 64'(rvld), 64'(4'b0010));
    check("en_rid_c6", 64'(rid), 64'(1));
    check("en_busy_c6", 64'(busy), 64'(0));
    tick(); en = 1'b1; #1;
    check("en_resume_c7", 64'(rdy), 64'(4'b0100));
    tick(); #1;
    check("en_resume_c8", 64'(rdy), 64'(4'b0001));
    vld = 4'b0000;

    // Asynchronous reset with reads in flight
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      tick(); vld = 4'b1111; #1;
      check($sformatf("ar_rdy_c%0d", c), 64'(rdy), 64'(1 << c));
    end
    tick(); #1;
    check("ar_mem_rd_pre", 64'(mem_rd), 64'(1));
    check("ar_busy_pre", 64'(busy), 64'(1));
    #2; rst_n = 1'b0; vld = 4'b0000; #1;
    check("ar_mem_rd_rst", 64'(mem_rd), 64'(0));
    check("ar_busy_rst", 64'(busy), 64'(0));
    check("ar_rvld_rst", 64'(rvld), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    seen_rvld = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(); #1;
      seen_rvld = seen_rvld | (|rvld);
    end
    check("ar_no_returns", 64'(seen_rvld), 64'(0));
    check("ar_busy_after", 64'(busy), 64'(0));
    tick(); vld = 4'b1111; #1;
    check("ar_first_grant", 64'(rdy), 64'(4'b0001));
    tick(); vld = 4'b0000;

    // READ_LATENCY=1 build
    tick(); vld1 = 4'b0100; req_addr1[2*AW +: AW] = 14'h2A5; #1;
    check("rl1_rdy_c0", 64'(rdy1), 64'(4'b0100));
    tick(); vld1 = 4'b0000; #1;
    check("rl1_mem_rd_c1", 64'(mem_rd1), 64'(1));
    check("rl1_raddr_c1", 64'(raddr1), 64'(14'h2A5));
    check("rl1_rvld_c1", 64'(rvld1), 64'(0));
    check("rl1_busy_c1", 64'(busy1), 64'(1));
    tick(); #1;
    exp_data1 = data1_of(14'h2A5);
    check("rl1_rvld_c2", 64'(rvld1), 64'(4'b0100));
    check("rl1_rid_c2", 64'(rid1), 64'(2));
    check("rl1_rdata_c2", 64'(rdata1), 64'(exp_data1));
    check("rl1_busy_c2", 64'(busy1), 64'(0));
    tick(); #1;
    check("rl1_rvld_c3", 64'(rvld1), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmip_mem_rd_arbiter.md
Name: cmip_mem_rd_arbiter

Overview:
- Round-robin arbiter that shares the single read port of a 1R1W block memory wrapper among NUM_REQ requesters.
- Accepts one read per cycle through a per-requester valid/ready handshake and drives the memory read address.
- Tracks each in-flight read through a tag pipeline matched to the memory's fixed READ_LATENCY.
- Returns the read data with a one-hot valid identifying the requester that owns it.

Parameters:
- NUM_REQ, 4, number of read requesters (2..8).
- DPTH, 16384, memory depth in words.
- DATA_WDTH, 2048, memory word width.
- ADDR_WDTH, $clog2(DPTH), address width.
- READ_LATENCY, 4, cycles from the memory sampling o_mem_rd/o_mem_raddr to data valid on i_mem_rdata (≥1).
- ID_WDTH, $clog2(NUM_REQ), width of the requester index.

Ports:
- i_clk, input, 1, single clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_en, input, 1, arbitration enable. Low blocks new grants; in-flight reads still complete.
- i_req_vld, input, NUM_REQ, per-requester read request valid.
- i_req_addr, input, NUM_REQ*ADDR_WDTH, per-requester address; requester k uses bits [k*ADDR_WDTH +: ADDR_WDTH].
- o_req_rdy, output, NUM_REQ, one-hot grant. Handshake completes when i_req_vld[k] and o_req_rdy[k] are both high.
- o_mem_rd, output, 1, memory read enable (registered).
- o_mem_raddr, output, ADDR_WDTH, memory read address (registered).
- i_mem_rdata, input, DATA_WDTH, memory read data.
- o_rvld, output, NUM_REQ, one-hot return valid, aligned to o_rdata.
- o_rid, output, ID_WDTH, index of the returning requester.
- o_rdata, output, DATA_WDTH, equals i_mem_rdata (combinational pass-through).
- o_busy, output, 1, high while any read is in flight in the tag pipeline.

Behaviour:
- Reset: o_mem_rd=0, o_mem_raddr=0, tag pipeline cleared, o_rvld=0, o_rid=0, o_busy=0, round-robin pointer=0.
- Reset mid-operation: all in-flight tags are discarded and no o_rvld is produced for them.
- Arbitration is combinational in cycle T.
  - o_req_rdy[k]=1 only if i_en=1, i_req_vld[k]=1, and k is the first requesting index searching upward from the pointer, with wrap.
  - At most one bit of o_req_rdy is set.
  - o_req_rdy is 0 whenever i_en=0.
- Pointer update: after a grant to k, the pointer becomes (k+1) mod NUM_REQ. With no grant, the pointer holds.
- Requesters must hold i_req_vld and i_req_addr stable until granted. The arbiter does not check this.
- Issue: a handshake in cycle T produces o_mem_rd=1 and o_mem_raddr = the granted address in cycle T+1. With no handshake, o_mem_rd=0 and o_mem_raddr holds its last value.
- One read is issued per cycle maximum. Back-to-back grants every cycle are required (full throughput).
- Tag pipeline: {valid, id} is captured alongside o_mem_rd and shifted READ_LATENCY stages.
  - Return occurs in cycle T+1+READ_LATENCY: o_rvld[id]=1 and o_rid=id.
  - At all other times o_rvld=0 and o_rid holds its last value.
- The return path has no backpressure; a requester must accept data in the o_rvld cycle.
- o_busy = OR of all tag-pipeline valid bits, including the o_mem_rd stage.
- Toggling i_en does not affect reads already issued.
- The write port is not controlled by this block. Same-cycle read/write to the same address returns the old data, which is the memory's behaviour.
- Address width is truncated/extended to exactly ADDR_WDTH with no range checking.

Test Plan:
- Single request: reset, then i_req_vld=4'b0010, addr1=0x123 held -> o_req_rdy=4'b0010 in cycle 0; o_mem_rd=1 with raddr=0x123 in cycle 1; o_rvld=4'b0010, o_rid=1, o_rdata=mem[0x123] in cycle 5 (READ_LATENCY=4); o_busy high in cycles 1-4, low in cycle 5.
- Round-robin: all four requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3 on consecutive cycles; returns appear in the same order in cycles 5..12, one per cycle.
- Fairness after skip: pointer=2, only requesters 0 and 3 valid -> grant 3, then 0, then 3.
- i_en low: i_en=0 with requests pending and two reads in flight -> o_req_rdy=0, in-flight o_rvld still delivered; i_en=1 resumes at the held pointer.
- Async reset mid-flight: assert i_rst_n=0 in cycle 2 after three grants -> o_mem_rd, o_rvld and o_busy drop immediately and no returns follow; after release, the first grant goes to requester 0.
- READ_LATENCY=1 build: single request -> o_rvld in cycle 2 after the handshake cycle.
